dma_bus_arbiter: RTL and testbench
==================================

# dma_bus_arbiter

Shares the Z80 core's external address/data/control bus between the CPU and up to NREQ bus-master requesters (DMA, video fetch, debugger). It sits beside `z80_top_direct` and drives the core's `nBUSRQ` input. It watches `nBUSACK`, grants one requester at a time in round-robin order, and bounds each tenure with a hold timeout. A mandatory CPU gap after each tenure guarantees CPU forward progress.

## Interface
- `NREQ`, default 2: number of requesters, 1..8.
- `MAX_HOLD`, default 64: maximum cycles a grant may last, ≥1.
- `GAP`, default 4: minimum cycles the CPU owns the bus between tenures, ≥0.
- `CLK` in 1: core clock, the same clock that drives the Z80 core.
- `nRESET` in 1: reset, synchronous and active-low. Sampled on the rising edge of `CLK`.
- `req` in NREQ: level request per requester; held high while the requester wants the bus.
- `gnt` out NREQ: one-hot-or-zero grant; requester i may drive A/D/controls only while `gnt[i]`=1.
- `nBUSRQ` out 1: active-low bus request to the Z80 core.
- `nBUSACK` in 1: active-low acknowledge from the Z80 core; synchronous to `CLK`, no synchronizer.
- `dma_active` out 1: high in GRANT (bus owned by a requester).
- `timeout` out 1: one-cycle pulse when a grant is ended by `MAX_HOLD` expiry.

## Operation
- All outputs are registered.
- Reset values:
  - `nBUSRQ`=1, `gnt`=0, `dma_active`=0, `timeout`=0.
  - state=IDLE, hold counter=0, gap counter=0.
  - Round-robin pointer `last`=NREQ-1, so `req[0]` wins first.
- Reset mid-operation: on the next edge `gnt` drops to 0 and `nBUSRQ` rises to 1, from any state. Requesters must tri-state on `gnt` falling.
- State machine:
  - IDLE: `nBUSRQ`=1. If any `req` is set, pick winner `w` = first set bit scanning upward from `last`+1 (mod NREQ). Latch `w` and go to REQ.
  - REQ: `nBUSRQ`=0. If `req[w]`=0, go to RELEASE (no grant issued). Otherwise, if `nBUSACK`=0, go to GRANT. Otherwise stay.
  - GRANT: `gnt[w]`=1, `dma_active`=1, `nBUSRQ`=0, hold counter increments each cycle from 0.
    - If `req[w]`=0, go to RELEASE.
    - Else if hold counter = MAX_HOLD-1, go to RELEASE and pulse `timeout`.
    - On exit from GRANT, `last`←`w`.
  - RELEASE: `gnt`=0, `nBUSRQ`=1. When `nBUSACK`=1, go to GAP; if GAP=0, go directly to IDLE.
  - GAP: gap counter counts GAP cycles, then go to IDLE. Requests are ignored in GAP.
- Only the latched winner is granted. Requests from others during REQ, GRANT or RELEASE wait for the next IDLE arbitration.
- A requester ended by timeout that still holds `req` re-arbitrates normally. With other requesters pending it loses to them, because `last`=`w`.
- Hold counter width is clog2(MAX_HOLD); the counter saturates and never wraps. Gap counter width is clog2(GAP+1).
- `gnt` is never high while `nBUSACK`=1, and never high in the same cycle the state leaves GRANT.

## Timing
- `req[i]` rising sampled at edge t in IDLE: `nBUSRQ` falls after edge t+1.
- `nBUSACK`=0 sampled at edge u in REQ: `gnt[w]` rises after edge u+1.
- `req[w]`=0 sampled at edge v in GRANT: `gnt[w]` falls and `nBUSRQ` rises together after edge v+1.
- Timeout: `gnt[w]` is high for exactly MAX_HOLD cycles. `timeout` is high for the single cycle in which `gnt` first reads 0.
- `nBUSACK`=1 sampled at edge r in RELEASE: the state leaves after edge r+1. The earliest next `nBUSRQ` fall is GAP+1 cycles after that.
- Simultaneous `req` rise and `nRESET`=0: reset wins.

## Test plan
- Reset: hold `nRESET`=0 for 3 cycles with `req`=2'b11 → `nBUSRQ`=1, `gnt`=0 throughout. After release, the first grant goes to `req[0]`.
- Single tenure:
  - Stimulus: `req[0]`=1; the core model asserts `nBUSACK` 5 cycles after `nBUSRQ` falls; `req[0]` drops after 10 granted cycles.
  - Required: `gnt[0]` is high exactly 10 cycles (±1 per the Timing edge rules). `nBUSRQ` rises with `gnt` falling. A second request is blocked for GAP=4 cycles after `nBUSACK` rises.
- Round robin: `req`=2'b11 held continuously with MAX_HOLD=8 → grants alternate 0,1,0,1; each lasts 8 cycles; `timeout` pulses once per tenure.
- Withdrawal in REQ: `req[1]` pulses for 2 cycles while the core delays `nBUSACK` by 6 → no `gnt` ever. `nBUSRQ` returns to 1 and the state reaches IDLE after `nBUSACK` rises.
- Reset mid-GRANT: `nRESET`=0 on the 3rd granted cycle → `gnt`=0 and `nBUSRQ`=1 on the next edge. After reset, `req[0]` is again first priority.
- Invariant check, random `req`/`nBUSACK` delays over 10k cycles: `gnt` is always one-hot-or-zero, and `gnt`≠0 implies `nBUSACK`=0.

Source files
------------

// File: rtl/dma_bus_arbiter.sv
// Round-robin arbiter that lends the Z80 external bus to NREQ bus masters via nBUSRQ/nBUSACK.
// Outputs are registered from the current state, so they trail state transitions by one cycle.
module dma_bus_arbiter #(
  parameter int NREQ     = 2,
  parameter int MAX_HOLD = 64,
  parameter int GAP      = 4
) (
  input  logic            CLK,
  input  logic            nRESET,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            nBUSRQ,
  input  logic            nBUSACK,
  output logic            dma_active,
  output logic            timeout
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_GRANT, S_RELEASE, S_GAP} state_t;

  state_t        state;
  logic [IW-1:0] winIdx;
  logic [IW-1:0] lastIdx;
  logic [HW-1:0] holdCnt;
  logic [GW-1:0] gapCnt;
  logic          toPend;

  // First requester strictly after 'last', wrapping; 'last' itself has lowest priority.
  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r, input logic [IW-1:0] last);
    logic [IW-1:0] w;
    int idx;
    w = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (r[idx]) w = IW'(idx);
    end
    return w;
  endfunction

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state      <= S_IDLE;
      winIdx     <= '0;
      lastIdx    <= IW'(NREQ - 1);
      holdCnt    <= '0;
      gapCnt     <= '0;
      toPend     <= 1'b0;
      gnt        <= '0;
      nBUSRQ     <= 1'b1;
      dma_active <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      gnt        <= (state == S_GRANT) ? (ONE << winIdx) : '0;
      nBUSRQ     <= !(state == S_REQ || state == S_GRANT);
      dma_active <= (state == S_GRANT);
      timeout    <= toPend;
      toPend     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            winIdx <= pick(req, lastIdx);
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (!req[winIdx]) state <= S_RELEASE;
          else if (!nBUSACK) begin
            holdCnt <= '0;
            state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Withdrawal takes priority over expiry, so no timeout pulse on a voluntary exit.
          if (!req[winIdx]) begin
            lastIdx <= winIdx;
            state   <= S_RELEASE;
          end else if (holdCnt == HW'(MAX_HOLD - 1)) begin
            lastIdx <= winIdx;
            toPend  <= 1'b1;
            state   <= S_RELEASE;
          end else begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (nBUSACK) begin
            gapCnt <= '0;
            state  <= (GAP == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (gapCnt == GW'(GAP - 1)) state <= S_IDLE;
          else gapCnt <= gapCnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: directed timing scenarios plus a randomized run checked
// against a transaction-level model of requesters and round-robin fairness.
module tb_dma_bus_arbiter;
  localparam int NREQ     = 3;
  localparam int MAX_HOLD = 8;
  localparam int GAP      = 4;

  logic            CLK = 1'b0;
  logic            nRESET;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            nBUSRQ;
  logic            nBUSACK = 1'b1;
  logic            dma_active;
  logic            timeout;

  int nCmp = 0;
  int nErr = 0;
  int ackDly = 2;
  int relDly = 1;
  int ackCnt = 0;
  int relCnt = 0;
  int mLast;

  dma_bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .GAP(GAP)) dut (
    .CLK(CLK), .nRESET(nRESET), .req(req), .gnt(gnt), .nBUSRQ(nBUSRQ),
    .nBUSACK(nBUSACK), .dma_active(dma_active), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  // Z80 core model: acknowledges ackDly cycles after nBUSRQ falls, releases relDly cycles after it rises.
  always @(posedge CLK) begin
    if (nBUSRQ === 1'b0) begin
      relCnt <= 0;
      if (nBUSACK) begin
        if (ackCnt >= ackDly - 1) begin nBUSACK <= 1'b0; ackCnt <= 0; end
        else ackCnt <= ackCnt + 1;
      end
    end else begin
      ackCnt <= 0;
      if (!nBUSACK) begin
        if (relCnt >= relDly - 1) begin nBUSACK <= 1'b1; relCnt <= 0; end
        else relCnt <= relCnt + 1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic int rrPick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oneHot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic wait_gnt(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (gnt != '0) begin ok = 1'b1; break; end
      tick();
    end
    if (gnt != '0) ok = 1'b1;
  endtask

  task automatic settle(output bit ok);
    req = '0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (gnt == '0 && nBUSRQ === 1'b1 && nBUSACK === 1'b1) begin ok = 1'b1; break; end
    end
    repeat (GAP + 4) tick();
  endtask

  task automatic test_reset();
    bit ok;
    nRESET = 1'b0;
    req = 3'b011;
    for (int i = 0; i < 3; i++) begin
      tick();
      nCmp++;
      if (nBUSRQ !== 1'b1 || gnt !== '0 || dma_active !== 1'b0 || timeout !== 1'b0) begin
        nErr++;
        $display("FAIL reset_hold: nBUSRQ=%b gnt=%b act=%b to=%b, need 1 000 0 0", nBUSRQ, gnt, dma_active, timeout);
      end
    end
    nRESET = 1'b1;
    mLast = NREQ - 1;
    wait_gnt(40, ok);
    nCmp++;
    if (!ok || gnt !== oneHot(rrPick(req, mLast))) begin
      nErr++;
      $display("FAIL reset_first_grant: gnt=%b, need %b", gnt, oneHot(rrPick(req, mLast)));
    end
    mLast = rrPick(req, mLast);
    settle(ok);
    nCmp++;
    if (!ok) begin nErr++; $display("FAIL reset_settle: bus not released, gnt=%b nBUSRQ=%b", gnt, nBUSRQ); end
  endtask

  task automatic test_single_tenure();
    bit ok;
    int k, len, first;
    ackDly = 5;
    req = 3'b001;
    tick();
    nCmp++;
    if (nBUSRQ !== 1'b1) begin nErr++; $display("FAIL busrq_early: nBUSRQ=%b, need 1", nBUSRQ); end
    tick();
    nCmp++;
    if (nBUSRQ !== 1'b0) begin nErr++; $display("FAIL busrq_latency: nBUSRQ=%b, need 0", nBUSRQ); end
    k = 0;
    while (nBUSACK !== 1'b0 && k < 20) begin tick(); k++; end
    k = 0;
    while (gnt == '0 && k < 10) begin tick(); k++; end
    nCmp++;
    if (k != 2 || gnt !== 3'b001 || dma_active !== 1'b1) begin
      nErr++;
      $display("FAIL ack_to_gnt: %0d cycles gnt=%b act=%b, need 2 cycles gnt=001 act=1", k, gnt, dma_active);
    end
    mLast = 0;
    len = 1;
    while (len < 5) begin
      tick();
      if (gnt == 3'b001) len++;
      else break;
    end
    req = '0;
    k = 0;
    while (gnt != '0 && k < 10) begin tick(); k++; if (gnt != '0) len++; end
    nCmp++;
    if (len != 6) begin nErr++; $display("FAIL tenure_len: gnt high %0d cycles, need 6", len); end
    nCmp++;
    if (nBUSRQ !== 1'b1 || timeout !== 1'b0 || dma_active !== 1'b0) begin
      nErr++;
      $display("FAIL release_edge: nBUSRQ=%b to=%b act=%b, need 1 0 0", nBUSRQ, timeout, dma_active);
    end
    req = 3'b001;
    k = 0;
    while (nBUSACK !== 1'b1 && k < 20) begin tick(); k++; end
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (nBUSRQ === 1'b0) begin first = i; break; end
    end
    nCmp++;
    if (first != GAP + 3) begin nErr++; $display("FAIL gap_block: nBUSRQ fell at %0d, need %0d", first, GAP + 3); end
    settle(ok);
    nCmp++;
    if (!ok) begin nErr++; $display("FAIL single_settle: bus not released"); end
  endtask

  task automatic test_round_robin();
    bit ok, toMid;
    int exp, len;
    ackDly = 2;
    req = 3'b011;
    for (int t = 0; t < 4; t++) begin
      wait_gnt(60, ok);
      exp = rrPick(req, mLast);
      nCmp++;
      if (!ok || gnt !== oneHot(exp)) begin
        nErr++;
        $display("FAIL rr_order: tenure %0d gnt=%b, need %b", t, gnt, oneHot(exp));
        break;
      end
      mLast = exp;
      len = 0;
      toMid = 1'b0;
      while (gnt != '0 && len < 20) begin
        len++;
        if (timeout) toMid = 1'b1;
        tick();
      end
      nCmp++;
      if (len != MAX_HOLD) begin nErr++; $display("FAIL rr_len: tenure %0d len=%0d, need %0d", t, len, MAX_HOLD); end
      nCmp++;
      if (timeout !== 1'b1 || toMid) begin
        nErr++;
        $display("FAIL rr_timeout: at gnt fall to=%b early=%b, need 1 0", timeout, toMid);
      end
      tick();
      nCmp++;
      if (timeout !== 1'b0) begin nErr++; $display("FAIL rr_timeout_width: to=%b, need 0", timeout); end
    end
    settle(ok);
    nCmp++;
    if (!ok) begin nErr++; $display("FAIL rr_settle: bus not released"); end
  endtask

  task automatic test_withdraw();
    bit ok, sawRq, sawG;
    ackDly = 6;
    sawRq = 1'b0;
    sawG = 1'b0;
    req = 3'b010;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (i == 1) req = '0;
      if (nBUSRQ === 1'b0) sawRq = 1'b1;
      if (gnt != '0) sawG = 1'b1;
    end
    nCmp++;
    if (sawG || !sawRq) begin nErr++; $display("FAIL withdraw_req: sawGnt=%b sawBusrq=%b, need 0 1", sawG, sawRq); end
    nCmp++;
    if (nBUSRQ !== 1'b1 || nBUSACK !== 1'b1) begin
      nErr++;
      $display("FAIL withdraw_release: nBUSRQ=%b nBUSACK=%b, need 1 1", nBUSRQ, nBUSACK);
    end
    ackDly = 2;
    req = 3'b001;
    tick();
    tick();
    nCmp++;
    if (nBUSRQ !== 1'b0) begin nErr++; $display("FAIL withdraw_idle: nBUSRQ=%b two cycles after req, need 0", nBUSRQ); end
    wait_gnt(40, ok);
    if (ok) mLast = 0;
    settle(ok);
    nCmp++;
    if (!ok) begin nErr++; $display("FAIL withdraw_settle: bus not released"); end
  endtask

  task automatic test_reset_mid_grant();
    bit ok;
    int k;
    ackDly = 2;
    req = 3'b001;
    wait_gnt(40, ok);
    tick();
    tick();
    nRESET = 1'b0;
    req = 3'b011;
    tick();
    nCmp++;
    if (gnt !== '0 || nBUSRQ !== 1'b1 || dma_active !== 1'b0) begin
      nErr++;
      $display("FAIL reset_mid_grant: gnt=%b nBUSRQ=%b act=%b, need 000 1 0", gnt, nBUSRQ, dma_active);
    end
    k = 0;
    while (nBUSACK !== 1'b1 && k < 20) begin tick(); k++; end
    tick();
    nRESET = 1'b1;
    mLast = NREQ - 1;
    wait_gnt(40, ok);
    nCmp++;
    if (!ok || gnt !== oneHot(rrPick(req, mLast))) begin
      nErr++;
      $display("FAIL prio_after_reset: gnt=%b, need %b", gnt, oneHot(rrPick(req, mLast)));
    end
    mLast = rrPick(req, mLast);
    settle(ok);
    nCmp++;
    if (!ok) begin nErr++; $display("FAIL reset_settle2: bus not released"); end
  endtask

  // Requesters raise req at random, hold it until served, then keep it for 'hold' granted cycles.
  task automatic test_random();
    int st[NREQ];
    int hold[NREQ];
    int gcnt[NREQ];
    int waitT[NREQ];
    logic [NREQ-1:0] prevGnt;
    bit expTo;
    int expLen;
    bit ok;
    for (int i = 0; i < NREQ; i++) begin st[i] = 0; hold[i] = 1; gcnt[i] = 0; waitT[i] = 0; end
    prevGnt = '0;
    req = '0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      expTo = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && !prevGnt[i]) begin
          nCmp++;
          if (st[i] != 1 || waitT[i] > NREQ - 1) begin
            nErr++;
            $display("FAIL rand_grant: cyc %0d req %0d pending=%0d waited=%0d tenures, need pending and <=%0d", c, i, st[i], waitT[i], NREQ - 1);
          end
          for (int j = 0; j < NREQ; j++) if (j != i && st[j] == 1) waitT[j]++;
          st[i] = 2;
          gcnt[i] = 0;
        end
        if (st[i] == 2) begin
          if (gnt[i]) begin
            gcnt[i]++;
            if (gcnt[i] == hold[i]) req[i] = 1'b0;
          end else begin
            expLen = (hold[i] + 1 < MAX_HOLD) ? hold[i] + 1 : MAX_HOLD;
            expTo = (hold[i] >= MAX_HOLD);
            nCmp++;
            if (gcnt[i] != expLen) begin
              nErr++;
              $display("FAIL rand_len: cyc %0d req %0d len=%0d, need %0d", c, i, gcnt[i], expLen);
            end
            if (req[i]) begin st[i] = 1; hold[i] = $urandom_range(1, 12); waitT[i] = 0; end
            else st[i] = 0;
          end
        end else if (st[i] == 0 && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b1;
          st[i] = 1;
          hold[i] = $urandom_range(1, 12);
          waitT[i] = 0;
        end
      end
      nCmp++;
      if (timeout !== expTo) begin nErr++; $display("FAIL rand_timeout: cyc %0d to=%b, need %b", c, timeout, expTo); end
      nCmp++;
      if ((gnt & (gnt - 1'b1)) != '0) begin nErr++; $display("FAIL rand_onehot: cyc %0d gnt=%b", c, gnt); end
      nCmp++;
      if (gnt != '0 && nBUSACK !== 1'b0) begin nErr++; $display("FAIL rand_gnt_ack: cyc %0d gnt=%b nBUSACK=%b, need ack 0", c, gnt, nBUSACK); end
      nCmp++;
      if (dma_active !== (gnt != '0)) begin nErr++; $display("FAIL rand_active: cyc %0d act=%b gnt=%b", c, dma_active, gnt); end
      prevGnt = gnt;
      if (nBUSRQ === 1'b1 && nBUSACK === 1'b1) begin
        ackDly = $urandom_range(1, 6);
        relDly = $urandom_range(1, 4);
      end
    end
    settle(ok);
    nCmp++;
    if (!ok) begin nErr++; $display("FAIL rand_settle: bus not released"); end
  endtask

  initial begin
    nRESET = 1'b0;
    req = '0;
    test_reset();
    test_single_tenure();
    test_round_robin();
    test_withdraw();
    test_reset_mid_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
